// File: rtl/thresholding_axilite_loader.sv
// thresholding_axilite_loader
//
// AXI-lite initiator that reloads the threshold memory of a thresholding
// kernel. A start pulse makes it consume C*(2^N-1) threshold words from an
// AXI stream. Each word becomes one AXI-lite write at its parameter address.
// With VERIFY set, each word is also read back and compared after the write.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start                 one-cycle pulse that begins a load (ignored while busy)
//   busy                  high while a load is in progress
//   done                  one-cycle pulse when the load completes
//   err_cnt               saturating count of bad responses and readback mismatches
//   s_axis_*              threshold word stream (value in tdata[WT-1:0])
//   m_axilite_AW*/W*/B*   write channels toward the kernel's config port
//   m_axilite_AR*/R*      read channels, used only when VERIFY is set
module thresholding_axilite_loader #(
  parameter int unsigned N        = 4,
  parameter int unsigned WT       = 8,
  parameter int unsigned C        = 1,
  parameter int unsigned in0_SDIM = 1,
  parameter int unsigned VERIFY   = 0,
  localparam int unsigned CF        = C / in0_SDIM,
  localparam int unsigned ADDR_BITS = $clog2(CF) + $clog2(in0_SDIM) + N + 2,
  localparam int unsigned TDW       = ((WT + 7) / 8) * 8
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          err_cnt,

  output logic                 s_axis_tready,
  input  logic                 s_axis_tvalid,
  input  logic [TDW-1:0]       s_axis_tdata,

  output logic                 m_axilite_AWVALID,
  input  logic                 m_axilite_AWREADY,
  output logic [ADDR_BITS-1:0] m_axilite_AWADDR,

  output logic                 m_axilite_WVALID,
  input  logic                 m_axilite_WREADY,
  output logic [31:0]          m_axilite_WDATA,
  output logic [3:0]           m_axilite_WSTRB,

  input  logic                 m_axilite_BVALID,
  output logic                 m_axilite_BREADY,
  input  logic [1:0]           m_axilite_BRESP,

  output logic                 m_axilite_ARVALID,
  input  logic                 m_axilite_ARREADY,
  output logic [ADDR_BITS-1:0] m_axilite_ARADDR,

  input  logic                 m_axilite_RVALID,
  output logic                 m_axilite_RREADY,
  input  logic [31:0]          m_axilite_RDATA,
  input  logic [1:0]           m_axilite_RRESP
);

  localparam int unsigned PE_BITS = $clog2(in0_SDIM);
  localparam int unsigned CF_BITS = $clog2(CF);
  // Counters keep at least one bit so degenerate dimensions stay legal.
  localparam int unsigned PE_W = (PE_BITS > 0) ? PE_BITS : 1;
  localparam int unsigned CF_W = (CF_BITS > 0) ? CF_BITS : 1;

  // Index 2^N-1 has no threshold, so t stops one short of all-ones.
  localparam logic [N-1:0]    T_LAST  = N'((2 ** N) - 2);
  localparam logic [PE_W-1:0] PE_LAST = PE_W'(in0_SDIM - 1);
  localparam logic [CF_W-1:0] CF_LAST = CF_W'(CF - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWr,
    StBrsp,
    StRd,
    StRrsp,
    StAdv,
    StDone
  } state_e;

  state_e                 state_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   tready_q;
  logic                   awvalid_q;
  logic                   wvalid_q;
  logic                   bready_q;
  logic                   arvalid_q;
  logic                   rready_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [WT-1:0]          data_q;
  logic [N-1:0]           t_q;
  logic [PE_W-1:0]        pe_q;
  logic [CF_W-1:0]        cf_q;
  logic [15:0]            err_q;

  logic [ADDR_BITS-1:0]   word_addr;
  logic                   last_word;
  logic                   aw_done;
  logic                   w_done;
  logic [15:0]            err_inc;

  // Byte address {cf, pe, t, 2'b00}, built by shifting so empty fields vanish.
  always_comb begin
    word_addr = ADDR_BITS'(t_q) << 2;
    word_addr = word_addr | (ADDR_BITS'(pe_q) << (N + 2));
    word_addr = word_addr | (ADDR_BITS'(cf_q) << (PE_BITS + N + 2));
  end

  assign last_word = (t_q == T_LAST) && (pe_q == PE_LAST) && (cf_q == CF_LAST);

  // A channel counts as done if it finished earlier or handshakes this cycle.
  assign aw_done = !awvalid_q || m_axilite_AWREADY;
  assign w_done  = !wvalid_q || m_axilite_WREADY;

  assign err_inc = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      t_q       <= '0;
      pe_q      <= '0;
      cf_q      <= '0;
      err_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            t_q      <= '0;
            pe_q     <= '0;
            cf_q     <= '0;
            err_q    <= '0;
            busy_q   <= 1'b1;
            tready_q <= 1'b1;
            state_q  <= StFetch;
          end
        end

        StFetch: begin
          if (s_axis_tvalid) begin
            tready_q  <= 1'b0;
            addr_q    <= word_addr;
            data_q    <= s_axis_tdata[WT-1:0];
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= StWr;
          end
        end

        StWr: begin
          if (m_axilite_AWREADY) begin
            awvalid_q <= 1'b0;
          end
          if (m_axilite_WREADY) begin
            wvalid_q <= 1'b0;
          end
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= StBrsp;
          end
        end

        StBrsp: begin
          if (m_axilite_BVALID) begin
            bready_q <= 1'b0;
            if (m_axilite_BRESP != 2'b00) begin
              err_q <= err_inc;
            end
            if (VERIFY != 0) begin
              arvalid_q <= 1'b1;
              state_q   <= StRd;
            end else begin
              state_q <= StAdv;
            end
          end
        end

        StRd: begin
          if (m_axilite_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRrsp;
          end
        end

        StRrsp: begin
          if (m_axilite_RVALID) begin
            rready_q <= 1'b0;
            // A bad response and a data mismatch on one beat count once.
            if ((m_axilite_RRESP != 2'b00) || (m_axilite_RDATA[WT-1:0] != data_q)) begin
              err_q <= err_inc;
            end
            state_q <= StAdv;
          end
        end

        StAdv: begin
          if (last_word) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StDone;
          end else begin
            if (t_q == T_LAST) begin
              t_q <= '0;
              if (pe_q == PE_LAST) begin
                pe_q <= '0;
                cf_q <= cf_q + CF_W'(1);
              end else begin
                pe_q <= pe_q + PE_W'(1);
              end
            end else begin
              t_q <= t_q + N'(1);
            end
            tready_q <= 1'b1;
            state_q  <= StFetch;
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign err_cnt           = err_q;
  assign s_axis_tready     = tready_q;
  assign m_axilite_AWVALID = awvalid_q;
  assign m_axilite_AWADDR  = addr_q;
  assign m_axilite_WVALID  = wvalid_q;
  assign m_axilite_WDATA   = 32'(data_q);
  assign m_axilite_WSTRB   = 4'hF;
  assign m_axilite_BREADY  = bready_q;
  assign m_axilite_ARVALID = arvalid_q;
  assign m_axilite_ARADDR  = (VERIFY != 0) ? addr_q : '0;
  assign m_axilite_RREADY  = rready_q;

  // Only the low WT bits of the stream and read data carry meaning.
  logic unused_bits;
  assign unused_bits = ^{s_axis_tdata, m_axilite_RDATA};

endmodule

// File: tb/tb_thresholding_axilite_loader.sv
module tb_thresholding_axilite_loader;

  localparam int unsigned ABA = 5;  // N=2, C=2, in0_SDIM=1
  localparam int unsigned ABB = 6;  // N=2, C=4, in0_SDIM=2

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A: VERIFY=0, always-ready slave ----------------
  logic           start_a = 1'b0;
  logic           busy_a, done_a, tready_a, tvalid_a;
  logic           awv_a, wv_a, bready_a, arv_a, rready_a;
  logic [15:0]    err_a;
  logic [7:0]     tdata_a;
  logic [ABA-1:0] awa_a, ara_a;
  logic [31:0]    wd_a;
  logic [3:0]     ws_a;
  logic           a_en = 1'b0;
  int             a_idx = 0;

  assign tvalid_a = a_en;
  assign tdata_a  = 8'(8'h10 + a_idx);

  thresholding_axilite_loader #(
    .N(2), .WT(8), .C(2), .in0_SDIM(1), .VERIFY(0)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .err_cnt(err_a),
    .s_axis_tready(tready_a), .s_axis_tvalid(tvalid_a), .s_axis_tdata(tdata_a),
    .m_axilite_AWVALID(awv_a), .m_axilite_AWREADY(1'b1), .m_axilite_AWADDR(awa_a),
    .m_axilite_WVALID(wv_a), .m_axilite_WREADY(1'b1), .m_axilite_WDATA(wd_a),
    .m_axilite_WSTRB(ws_a),
    .m_axilite_BVALID(1'b1), .m_axilite_BREADY(bready_a), .m_axilite_BRESP(2'b00),
    .m_axilite_ARVALID(arv_a), .m_axilite_ARREADY(1'b1), .m_axilite_ARADDR(ara_a),
    .m_axilite_RVALID(1'b1), .m_axilite_RREADY(rready_a), .m_axilite_RDATA(32'h0),
    .m_axilite_RRESP(2'b00)
  );

  logic [ABA-1:0] a_wa [0:15];
  logic [31:0]    a_wd [0:15];
  int             a_cyc [0:15];
  int             a_nw = 0, a_nd = 0, a_done_n = 0, a_bad_strb = 0, a_ar_seen = 0;

  always @(posedge clk) begin
    if (tvalid_a && tready_a) a_idx <= a_idx + 1;
    if (awv_a && a_nw < 16) begin
      a_wa[a_nw]  <= awa_a;
      a_cyc[a_nw] <= cyc;
      a_nw        <= a_nw + 1;
    end
    if (wv_a && a_nd < 16) begin
      a_wd[a_nd] <= wd_a;
      a_nd       <= a_nd + 1;
      if (ws_a != 4'hF) a_bad_strb <= a_bad_strb + 1;
    end
    if (done_a) a_done_n <= a_done_n + 1;
    if (arv_a) a_ar_seen <= a_ar_seen + 1;
  end

  // ---------------- DUT B: VERIFY=1, programmable slave ----------------
  logic           start_b = 1'b0;
  logic           busy_b, done_b, tready_b, tvalid_b;
  logic           awv_b, awready_b, wv_b, wready_b, bvalid_b, bready_b;
  logic           arv_b, arready_b, rvalid_b, rready_b;
  logic [1:0]     bresp_b;
  logic [15:0]    err_b;
  logic [7:0]     tdata_b;
  logic [ABB-1:0] awa_b, ara_b;
  logic [31:0]    wd_b, rdata_b;
  logic [3:0]     ws_b;

  logic clr = 1'b0;
  logic b_en = 1'b0;
  int   b_lim = 12;
  int   aw_delay = 0, w_delay = 0, bad_b = 99, bad_r = 99;

  int          b_idx = 0, aw_wait = 0, w_wait = 0, b_cnt = 0, r_cnt = 0;
  logic        aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
  logic [5:0]  lat_addr;
  logic [31:0] lat_data;
  logic [3:0]  r_addr = 4'd0;
  logic [31:0] mem [0:15];

  logic [ABB-1:0] b_wa [0:15];
  logic [31:0]    b_wd [0:15];
  int             b_nw = 0, b_nd = 0, b_done_n = 0, b_awonly = 0, b_viol = 0;

  assign tvalid_b  = b_en && (b_idx < b_lim);
  assign tdata_b   = 8'(8'hA0 + b_idx);
  assign awready_b = awv_b && (aw_wait >= aw_delay);
  assign wready_b  = wv_b && (w_wait >= w_delay);
  assign bvalid_b  = b_pend;
  assign bresp_b   = (b_cnt == bad_b) ? 2'b10 : 2'b00;
  assign arready_b = arv_b;
  assign rvalid_b  = r_pend;
  assign rdata_b   = mem[r_addr] ^ ((r_cnt == bad_r) ? 32'h0000_00FF : 32'h0);

  thresholding_axilite_loader #(
    .N(2), .WT(8), .C(4), .in0_SDIM(2), .VERIFY(1)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .err_cnt(err_b),
    .s_axis_tready(tready_b), .s_axis_tvalid(tvalid_b), .s_axis_tdata(tdata_b),
    .m_axilite_AWVALID(awv_b), .m_axilite_AWREADY(awready_b), .m_axilite_AWADDR(awa_b),
    .m_axilite_WVALID(wv_b), .m_axilite_WREADY(wready_b), .m_axilite_WDATA(wd_b),
    .m_axilite_WSTRB(ws_b),
    .m_axilite_BVALID(bvalid_b), .m_axilite_BREADY(bready_b), .m_axilite_BRESP(bresp_b),
    .m_axilite_ARVALID(arv_b), .m_axilite_ARREADY(arready_b), .m_axilite_ARADDR(ara_b),
    .m_axilite_RVALID(rvalid_b), .m_axilite_RREADY(rready_b), .m_axilite_RDATA(rdata_b),
    .m_axilite_RRESP(2'b00)
  );

  always @(posedge clk) begin
    if (rst || clr) begin
      aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      b_pend <= 1'b0; r_pend <= 1'b0; b_cnt <= 0; r_cnt <= 0; b_idx <= 0;
      b_nw <= 0; b_nd <= 0; b_done_n <= 0; b_awonly <= 0; b_viol <= 0;
    end else begin
      aw_wait <= (awv_b && !awready_b) ? aw_wait + 1 : 0;
      w_wait  <= (wv_b && !wready_b) ? w_wait + 1 : 0;
      if (tvalid_b && tready_b) b_idx <= b_idx + 1;
      if (awv_b && awready_b) begin
        aw_got   <= 1'b1;
        lat_addr <= awa_b;
        if (b_nw < 16) b_wa[b_nw] <= awa_b;
        b_nw <= b_nw + 1;
      end
      if (wv_b && wready_b) begin
        w_got    <= 1'b1;
        lat_data <= wd_b;
        if (b_nd < 16) b_wd[b_nd] <= wd_b;
        b_nd <= b_nd + 1;
      end
      if (aw_got && w_got) begin
        mem[lat_addr[5:2]] <= lat_data;
        b_pend <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (b_pend && bready_b) begin
        b_pend <= 1'b0;
        b_cnt  <= b_cnt + 1;
      end
      if (arv_b && arready_b) begin
        r_pend <= 1'b1;
        r_addr <= ara_b[5:2];
      end
      if (r_pend && rready_b) begin
        r_pend <= 1'b0;
        r_cnt  <= r_cnt + 1;
      end
      if (done_b) b_done_n <= b_done_n + 1;
      if (awv_b && !wv_b) b_awonly <= b_awonly + 1;
      if (bready_b && awv_b) b_viol <= b_viol + 1;
    end
  end

  // Word i of DUT B: channel i/3, index i%3; cf = ch/2, pe = ch%2.
  function automatic logic [ABB-1:0] exp_addr_b(input int i);
    int ch;
    ch = i / 3;
    return ABB'((ch / 2) * 32 + (ch % 2) * 16 + (i % 3) * 4);
  endfunction

  task automatic wait_done_b(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done_b) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy_b, done_b, tready_b, awv_b, wv_b, bready_b, arv_b, rready_b} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl_b got %b want 00000000",
               {busy_b, done_b, tready_b, awv_b, wv_b, bready_b, arv_b, rready_b});
    end
    checks++;
    if ({awa_b, ara_b, wd_b, err_b} !== 60'h0) begin
      errors++;
      $display("FAIL reset_data_b got addr=%h/%h wdata=%h err=%0d want all 0",
               awa_b, ara_b, wd_b, err_b);
    end
    checks++;
    if ({busy_a, done_a, tready_a, awv_a, wv_a, bready_a, arv_a, rready_a} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl_a got %b want 00000000",
               {busy_a, done_a, tready_a, awv_a, wv_a, bready_a, arv_a, rready_a});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_a, busy_b, tready_a, tready_b} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_reset got %b want 0000", {busy_a, busy_b, tready_a, tready_b});
    end
  endtask

  task automatic test_basic_noverify();
    logic [ABA-1:0] exp_a [0:5];
    bit ok;
    exp_a = '{5'h00, 5'h04, 5'h08, 5'h10, 5'h14, 5'h18};
    a_en = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    checks++;
    if ({busy_a, tready_a} !== 2'b11) begin
      errors++;
      $display("FAIL a_start_latency got busy,tready=%b want 11", {busy_a, tready_a});
    end
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_a) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL a_done_timeout got no done want done within 60 cycles");
    end
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL a_busy_at_done got %b want 0", busy_a);
    end
    a_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (a_nw != 6 || a_nd != 6) begin
      errors++;
      $display("FAIL a_write_count got aw=%0d w=%0d want 6/6", a_nw, a_nd);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (a_wa[i] !== exp_a[i] || a_wd[i] !== 32'h10 + i) begin
        errors++;
        $display("FAIL a_word%0d got addr=%h data=%h want addr=%h data=%h",
                 i, a_wa[i], a_wd[i], exp_a[i], 32'h10 + i);
      end
    end
    for (int i = 1; i < 6; i++) begin
      checks++;
      if (a_cyc[i] - a_cyc[i-1] != 4) begin
        errors++;
        $display("FAIL a_period%0d got %0d cycles want 4", i, a_cyc[i] - a_cyc[i-1]);
      end
    end
    checks++;
    if (err_a !== 16'd0 || a_done_n != 1 || a_bad_strb != 0) begin
      errors++;
      $display("FAIL a_status got err=%0d dones=%0d badstrb=%0d want 0/1/0",
               err_a, a_done_n, a_bad_strb);
    end
    checks++;
    if (a_ar_seen != 0 || ara_a !== 5'h0) begin
      errors++;
      $display("FAIL a_no_read got arvalid_cycles=%0d araddr=%h want 0/0", a_ar_seen, ara_a);
    end
  endtask

  task automatic test_map_verify();
    bit ok;
    pulse_clr();
    aw_delay = 0; w_delay = 0; bad_b = 4; bad_r = 2; b_lim = 12; b_en = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    checks++;
    if ({busy_b, tready_b} !== 2'b11) begin
      errors++;
      $display("FAIL b_start_latency got busy,tready=%b want 11", {busy_b, tready_b});
    end
    wait_done_b(400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b_done_timeout got no done want done within 400 cycles");
    end
    checks++;
    if (err_b !== 16'd2 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL b_err_at_done got err=%0d busy=%b want err=2 busy=0", err_b, busy_b);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (b_nw != 12 || b_nd != 12 || r_cnt != 12) begin
      errors++;
      $display("FAIL b_counts got aw=%0d w=%0d r=%0d want 12/12/12", b_nw, b_nd, r_cnt);
    end
    checks++;
    if (b_wa[3] !== 6'h10 || b_wa[6] !== 6'h20) begin
      errors++;
      $display("FAIL b_channel_base got ch1=%h ch2=%h want 10/20", b_wa[3], b_wa[6]);
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (b_wa[i] !== exp_addr_b(i) || b_wd[i] !== 32'hA0 + i) begin
        errors++;
        $display("FAIL b_word%0d got addr=%h data=%h want addr=%h data=%h",
                 i, b_wa[i], b_wd[i], exp_addr_b(i), 32'hA0 + i);
      end
    end
  endtask

  task automatic test_aw_late();
    bit ok;
    pulse_clr();
    aw_delay = 3; w_delay = 0; bad_b = 99; bad_r = 99; b_lim = 12; b_en = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    wait_done_b(600, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL late_done_timeout got no done want done within 600 cycles");
    end
    checks++;
    if (b_awonly != 36) begin
      errors++;
      $display("FAIL late_aw_only_cycles got %0d want 36", b_awonly);
    end
    checks++;
    if (b_viol != 0) begin
      errors++;
      $display("FAIL late_bready_before_aw got %0d cycles want 0", b_viol);
    end
    checks++;
    if (err_b !== 16'd0 || b_nw != 12 || b_wa[11] !== 6'h38) begin
      errors++;
      $display("FAIL late_status got err=%0d writes=%0d last=%h want 0/12/38",
               err_b, b_nw, b_wa[11]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    pulse_clr();
    aw_delay = 20; w_delay = 0; b_lim = 12; b_en = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (awv_b) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mid_reach_wr got no AWVALID want AWVALID within 10 cycles");
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy_b, done_b, tready_b, awv_b, wv_b, bready_b, arv_b, rready_b} !== 8'h00) begin
      errors++;
      $display("FAIL mid_abandon got %b want 00000000",
               {busy_b, done_b, tready_b, awv_b, wv_b, bready_b, arv_b, rready_b});
    end
    rst = 1'b0;
    aw_delay = 0;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    wait_done_b(400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mid_reload_timeout got no done want done within 400 cycles");
    end
    repeat (2) @(negedge clk);
    checks++;
    if (b_nw != 12 || b_wa[0] !== 6'h00 || b_wd[0] !== 32'hA0 || b_wa[11] !== 6'h38) begin
      errors++;
      $display("FAIL mid_reload got writes=%0d first=%h/%h last=%h want 12 00/a0 38",
               b_nw, b_wa[0], b_wd[0], b_wa[11]);
    end
    checks++;
    if (err_b !== 16'd0 || b_done_n != 1) begin
      errors++;
      $display("FAIL mid_status got err=%0d dones=%0d want 0/1", err_b, b_done_n);
    end
  endtask

  task automatic test_start_busy();
    bit ok;
    pulse_clr();
    aw_delay = 0; w_delay = 0; b_lim = 4; b_en = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b_idx == 4 && tready_b) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL busy_reach_stall got idx=%0d want idx=4 with tready", b_idx);
    end
    for (int i = 0; i < 10; i++) begin
      start_b = (i == 3);
      @(negedge clk);
    end
    start_b = 1'b0;
    checks++;
    if ({busy_b, tready_b} !== 2'b11 || b_nw != 4) begin
      errors++;
      $display("FAIL busy_held got busy,tready=%b writes=%0d want 11 4",
               {busy_b, tready_b}, b_nw);
    end
    b_lim = 12;
    wait_done_b(400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL busy_done_timeout got no done want done within 400 cycles");
    end
    repeat (3) @(negedge clk);
    checks++;
    if (b_nw != 12 || b_done_n != 1 || err_b !== 16'd0) begin
      errors++;
      $display("FAIL busy_status got writes=%0d dones=%0d err=%0d want 12/1/0",
               b_nw, b_done_n, err_b);
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (b_wa[i] !== exp_addr_b(i)) begin
        errors++;
        $display("FAIL busy_addr%0d got %h want %h", i, b_wa[i], exp_addr_b(i));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic_noverify();
    test_map_verify();
    test_aw_late();
    test_reset_mid();
    test_start_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
